bit_stream_tx: RTL and testbench
================================

// Module: bit_stream_tx
// PURPOSE
//  Transmit end of the serial bit-pattern link. Accepts parallel words over a valid/ready
//  handshake and serializes them, one bit per clock, onto w for the overlapping 110/101
//  Moore detector. Also counts the 110/101 occurrences in the transmitted stream, so the
//  system can cross-check detector pulses.
// PARAMETERS
//  WIDTH      8   bits per word (>=2)
//  GAP        1   idle cycles after each word (0 allowed); w=0, w_valid=0 during gap
//  MSB_FIRST  1   1: din[WIDTH-1] sent first; 0: din[0] sent first
//  CNT_W      8   width of the saturating hit counter
// PORTS
//  clk          in   1        rising-edge clock
//  reset        in   1        asynchronous, active-high reset
//  din          in   WIDTH    word to transmit
//  din_valid    in   1        din presented
//  din_ready    out  1        block can accept a word this cycle
//  w            out  1        serial data bit
//  w_valid      out  1        w carries a data bit this cycle
//  frame_start  out  1        high on the first bit of each word
//  busy         out  1        state != IDLE
//  hit          out  1        1-cycle pulse: last 3 valid bits were 110 or 101
//  hit_cnt      out  CNT_W    saturating count of hit pulses since reset
// BEHAVIOUR
//  - Reset (async, active-high): state=IDLE; w, w_valid, frame_start, hit=0; hit_cnt=0;
//    bit history cleared. An in-flight word is discarded with no partial resume.
//  - din_ready = (state==IDLE) & ~reset. It is the only output that is combinational
//    from state; all other outputs are registered.
//  - FSM states: IDLE, SHIFT, GAP.
//    IDLE : on din_valid & din_ready, load the shift register and clear the bit
//           counter -> SHIFT.
//    SHIFT: drive one bit per cycle, WIDTH cycles, w_valid=1. frame_start=1 on bit 0 only.
//           After bit WIDTH-1: -> GAP if GAP>0, else -> IDLE.
//    GAP  : GAP cycles with w=0, w_valid=0 -> IDLE.
//  - Latency: first bit on w in the cycle after the handshake cycle.
//  - Throughput: one word per WIDTH+GAP+1 cycles. No acceptance during SHIFT or GAP.
//  - din_valid asserted while din_ready=0 is ignored; the word is not captured.
//  - Hit logic: 2-bit history h updates only on cycles with w_valid=1.
//    The next-cycle hit pulse is asserted when {h[1],h[0],w} is 110 or 101.
//    Windows overlap and span word boundaries; gap cycles do not enter the history.
//  - hit_cnt increments on each hit pulse and sticks at 2^CNT_W-1 (no wrap).
//  - Reset asserted mid-word: outputs go to reset values immediately. Transmission
//    restarts only on a new handshake after reset is released.
// STRUCTURE
//  - Shared package: state encodings (IDLE=2'd0, SHIFT=2'd1, GAP=2'd2) and the
//    pattern constants 3'b110 and 3'b101.
//  - Sub-module pattern_hit_counter(clk, reset, bit_in, bit_valid, hit, hit_cnt):
//    owns the history register, the pattern compare and the saturating counter.
//  - Top level holds the FSM, shift register, bit counter (clog2(WIDTH)) and gap
//    counter (clog2(GAP+1)).
// TESTING
//  1. Reset held, din_valid=1 -> din_ready=0, w_valid=0, hit_cnt=0. Release reset ->
//     din_ready=1 in the next cycle.
//  2. WIDTH=8, MSB_FIRST=1, din=8'b1101_0110 -> w=1,1,0,1,0,1,1,0 on 8 cycles starting
//     1 cycle after the handshake; frame_start only on the first; 4 hits; hit_cnt=4.
//  3. Back-to-back words 8'hFF then 8'h00, din_valid held high, GAP=1 -> second word's
//     first bit exactly 10 cycles after the first; exactly 1 hit (110 across the boundary).
//  4. GAP=0, MSB_FIRST=0, din=8'b0000_0101 -> w=1,0,1,0,0,0,0,0; 1 hit; din_ready high
//     in the cycle after the last bit.
//  5. Reset asserted at bit 4 of a word -> w_valid=0 and hit_cnt=0 immediately; after
//     release, no bits are sent until a new handshake.
//  6. CNT_W=2, stream 1010101010 -> hit_cnt reaches 3 and stays at 3.

Source files
------------

// File: rtl/bit_stream_tx_pkg.sv
// Shared definitions for the bit-stream transmitter: FSM encodings and the
// two 3-bit patterns watched for in the outgoing stream.
package bit_stream_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [2:0] PAT_110 = 3'b110;
  localparam logic [2:0] PAT_101 = 3'b101;

  // True when a 3-bit window (oldest bit in [2]) matches either pattern.
  function automatic logic is_pattern(input logic [2:0] window);
    return (window == PAT_110) || (window == PAT_101);
  endfunction

endpackage

// File: rtl/bit_stream_tx_hit.sv
// Watches the valid bits of the serial stream and pulses hit one cycle after
// the last three valid bits form 110 or 101. Keeps a saturating hit count.
module pattern_hit_counter
  import bit_stream_tx_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             hit,
  output logic [CNT_W-1:0] hit_cnt
);

  logic [1:0] hist;
  logic       match;

  assign match = bit_valid && is_pattern({hist, bit_in});

  // History advances only on valid bits; hit and count update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist    <= 2'b00;
      hit     <= 1'b0;
      hit_cnt <= '0;
    end else begin
      hit <= match;
      if (bit_valid) begin
        hist <= {hist[0], bit_in};
      end
      if (match && (hit_cnt != {CNT_W{1'b1}})) begin
        hit_cnt <= hit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bit_stream_tx.sv
// Serializer for the 110/101 detector link. Accepts a word on a valid/ready
// handshake, sends it one bit per clock, then idles GAP cycles.
//
// state    | meaning
// ST_IDLE  | waiting for din_valid; din_ready high
// ST_SHIFT | a data bit is on w, bit_cnt is its index in the word
// ST_GAP   | inter-word idle, w=0, w_valid=0
module bit_stream_tx
  import bit_stream_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int GAP       = 1,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             w,
  output logic             w_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             hit,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int BCW = $clog2(WIDTH);
  localparam int GCW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
  localparam logic [GCW-1:0] GAP_LOAD = (GAP > 0) ? GCW'(GAP - 1) : '0;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [BCW-1:0]   bit_cnt;
  logic [GCW-1:0]   gap_cnt;

  function automatic logic head(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  assign din_ready = (state == ST_IDLE) && !reset;

  // Sequencer: the first bit is registered onto w during the handshake cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      w           <= 1'b0;
      w_valid     <= 1'b0;
      frame_start <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          w           <= 1'b0;
          w_valid     <= 1'b0;
          frame_start <= 1'b0;
          if (din_valid && din_ready) begin
            state       <= ST_SHIFT;
            busy        <= 1'b1;
            shreg       <= advance(din);
            w           <= head(din);
            w_valid     <= 1'b1;
            frame_start <= 1'b1;
            bit_cnt     <= '0;
          end
        end
        ST_SHIFT: begin
          frame_start <= 1'b0;
          if (bit_cnt == LAST_BIT) begin
            w       <= 1'b0;
            w_valid <= 1'b0;
            if (GAP > 0) begin
              state   <= ST_GAP;
              gap_cnt <= GAP_LOAD;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            w       <= head(shreg);
            shreg   <= advance(shreg);
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          w       <= 1'b0;
          w_valid <= 1'b0;
          if (gap_cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          busy        <= 1'b0;
          w           <= 1'b0;
          w_valid     <= 1'b0;
          frame_start <= 1'b0;
        end
      endcase
    end
  end

  pattern_hit_counter #(.CNT_W(CNT_W)) u_hit (
    .clk       (clk),
    .reset     (reset),
    .bit_in    (w),
    .bit_valid (w_valid),
    .hit       (hit),
    .hit_cnt   (hit_cnt)
  );

endmodule

// File: tb/tb_bit_stream_tx.sv
// Directed bench for bit_stream_tx: three instances cover the default
// configuration, GAP=0 with LSB-first order, and a 2-bit hit counter.
module tb_bit_stream_tx;

  logic clk = 1'b0;
  logic reset;

  logic [7:0] din_a, din_b, din_c;
  logic       din_valid_a, din_valid_b, din_valid_c;
  logic       din_ready_a, w_a, w_valid_a, frame_start_a, busy_a, hit_a;
  logic       din_ready_b, w_b, w_valid_b, frame_start_b, busy_b, hit_b;
  logic       din_ready_c, w_c, w_valid_c, frame_start_c, busy_c, hit_c;
  logic [7:0] hit_cnt_a, hit_cnt_b;
  logic [1:0] hit_cnt_c;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  bit_stream_tx #(.WIDTH(8), .GAP(1), .MSB_FIRST(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .din(din_a), .din_valid(din_valid_a),
    .din_ready(din_ready_a), .w(w_a), .w_valid(w_valid_a),
    .frame_start(frame_start_a), .busy(busy_a), .hit(hit_a), .hit_cnt(hit_cnt_a)
  );

  bit_stream_tx #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b0), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .din(din_b), .din_valid(din_valid_b),
    .din_ready(din_ready_b), .w(w_b), .w_valid(w_valid_b),
    .frame_start(frame_start_b), .busy(busy_b), .hit(hit_b), .hit_cnt(hit_cnt_b)
  );

  bit_stream_tx #(.WIDTH(8), .GAP(1), .MSB_FIRST(1'b1), .CNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .din(din_c), .din_valid(din_valid_c),
    .din_ready(din_ready_c), .w(w_c), .w_valid(w_valid_c),
    .frame_start(frame_start_c), .busy(busy_c), .hit(hit_c), .hit_cnt(hit_cnt_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [7:0]  exp_w;
  logic [15:0] exp_hit;
  int          hits;
  int          wv_seen;

  initial begin
    reset = 1'b1;
    din_a = 8'hD6; din_b = 8'h00; din_c = 8'h00;
    din_valid_a = 1'b1; din_valid_b = 1'b0; din_valid_c = 1'b0;

    // 1: reset held with din_valid high
    repeat (3) tick();
    chk("rst_din_ready", 32'(din_ready_a), 32'd0);
    chk("rst_w_valid",   32'(w_valid_a),   32'd0);
    chk("rst_hit_cnt",   32'(hit_cnt_a),   32'd0);
    chk("rst_busy",      32'(busy_a),      32'd0);
    reset = 1'b0;
    din_valid_a = 1'b0;
    tick();
    chk("rel_din_ready", 32'(din_ready_a), 32'd1);
    chk("rel_w_valid",   32'(w_valid_a),   32'd0);

    // 2: single MSB-first word 1101_0110, hits after bits 3,4,6,8
    exp_w   = 8'hD6;
    exp_hit = 16'h0158;
    din_a = 8'hD6; din_valid_a = 1'b1;
    tick();
    din_valid_a = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) begin
        chk("t2_w",       32'(w_a),           32'(exp_w[7-i]));
        chk("t2_w_valid", 32'(w_valid_a),     32'd1);
        chk("t2_frame",   32'(frame_start_a), (i == 0) ? 32'd1 : 32'd0);
        chk("t2_ready",   32'(din_ready_a),   32'd0);
      end else begin
        chk("t2_w_valid_off", 32'(w_valid_a), 32'd0);
      end
      chk("t2_hit", 32'(hit_a), 32'(exp_hit[i]));
      tick();
    end
    chk("t2_hit_cnt", 32'(hit_cnt_a), 32'd4);

    // 3: back-to-back FF then 00, second word 10 cycles later, one boundary hit
    reset_pulse();
    din_a = 8'hFF; din_valid_a = 1'b1;
    tick();
    din_a = 8'h00;
    for (int i = 0; i < 23; i++) begin
      chk("t3_frame", 32'(frame_start_a), (i == 0 || i == 10) ? 32'd1 : 32'd0);
      chk("t3_hit",   32'(hit_a),         (i == 11) ? 32'd1 : 32'd0);
      if (i == 8)  chk("t3_gap_w_valid", 32'(w_valid_a), 32'd0);
      if (i == 9)  chk("t3_gap_ready",   32'(din_ready_a), 32'd1);
      if (i == 10) begin
        chk("t3_w2_valid", 32'(w_valid_a), 32'd1);
        chk("t3_w2_bit",   32'(w_a),       32'd0);
        din_valid_a = 1'b0;
      end
      tick();
    end
    chk("t3_hit_cnt", 32'(hit_cnt_a), 32'd1);

    // 4: GAP=0, LSB first, 0000_0101 -> 1,0,1,0,0,0,0,0
    reset_pulse();
    exp_w = 8'h05;
    din_b = 8'h05; din_valid_b = 1'b1;
    tick();
    din_valid_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        chk("t4_w",       32'(w_b),         32'(exp_w[i]));
        chk("t4_w_valid", 32'(w_valid_b),   32'd1);
        chk("t4_ready",   32'(din_ready_b), 32'd0);
      end
      if (i == 8) begin
        chk("t4_ready_after", 32'(din_ready_b), 32'd1);
        chk("t4_w_valid_off", 32'(w_valid_b),   32'd0);
      end
      chk("t4_hit", 32'(hit_b), (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    chk("t4_hit_cnt", 32'(hit_cnt_b), 32'd1);

    // 5: reset during bit 4 of a word
    reset_pulse();
    din_a = 8'hD6; din_valid_a = 1'b1;
    tick();
    din_valid_a = 1'b0;
    repeat (4) tick();
    chk("t5_pre_w_valid", 32'(w_valid_a), 32'd1);
    chk("t5_pre_hit_cnt", 32'(hit_cnt_a), 32'd2);
    reset = 1'b1;
    #1;
    chk("t5_w_valid", 32'(w_valid_a),   32'd0);
    chk("t5_hit_cnt", 32'(hit_cnt_a),   32'd0);
    chk("t5_ready",   32'(din_ready_a), 32'd0);
    chk("t5_busy",    32'(busy_a),      32'd0);
    tick();
    reset = 1'b0;
    wv_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      wv_seen += int'(w_valid_a) + int'(busy_a);
    end
    chk("t5_quiet", 32'(wv_seen), 32'd0);
    din_a = 8'h80; din_valid_a = 1'b1;
    tick();
    din_valid_a = 1'b0;
    chk("t5_restart_w",     32'(w_a),           32'd1);
    chk("t5_restart_frame", 32'(frame_start_a), 32'd1);

    // 6: CNT_W=2, two words of 1010_1010 -> 7 hit pulses, count sticks at 3
    reset_pulse();
    din_c = 8'hAA; din_valid_c = 1'b1;
    tick();
    hits = 0;
    for (int i = 0; i < 30; i++) begin
      hits += int'(hit_c);
      if (i == 7) chk("t6_cnt_full", 32'(hit_cnt_c), 32'd3);
      if (i == 10) din_valid_c = 1'b0;
      tick();
    end
    chk("t6_hit_pulses", 32'(hits),      32'd7);
    chk("t6_cnt_sat",    32'(hit_cnt_c), 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
